// File: rtl/uart_baud_gen_pkg.sv
// Package: uart_baud_gen_pkg
// Default widths, shared types and the channel-mode selector for the baud generator.
package uart_baud_gen_pkg;

    localparam int DIV_W_DEF  = 16;
    localparam int OVS_DEF    = 16;  // even, 8..32
    localparam int FRAC_W_DEF = 4;
    localparam int MID_DEF    = OVS_DEF / 2;

    typedef logic [DIV_W_DEF-1:0]       div_t;
    typedef logic [$clog2(OVS_DEF)-1:0] ovs_cnt_t;

    typedef enum logic {
        CH_RX = 1'b0,
        CH_TX = 1'b1
    } ch_mode_e;

    typedef struct packed {
        logic vote;
        logic sample;
        logic xmit;
    } edges_t;

endpackage

// File: rtl/uart_baud_gen_if.sv
// Interface: uart_baud_gen_if
// Register-file side (master) and generator side (slave) of the baud generator; dlf exists only with UART_FRAC_DIV_EN.
interface uart_baud_gen_if
    import uart_baud_gen_pkg::*;
;
    logic                  en;
    logic                  rx_clr;
    logic                  tx_clr;
    logic [7:0]            dlh;
    logic [7:0]            dll;
`ifdef UART_FRAC_DIV_EN
    logic [FRAC_W_DEF-1:0] dlf;
`endif
    logic                  voting_edge;
    logic                  sample_edge;
    logic                  transmit_edge;

    modport master (
        output en, rx_clr, tx_clr, dlh, dll,
`ifdef UART_FRAC_DIV_EN
        output dlf,
`endif
        input  voting_edge, sample_edge, transmit_edge
    );

    modport slave (
        input  en, rx_clr, tx_clr, dlh, dll,
`ifdef UART_FRAC_DIV_EN
        input  dlf,
`endif
        output voting_edge, sample_edge, transmit_edge
    );

endinterface

// File: rtl/uart_baud_gen_ch.sv
// Module: uart_baud_gen_ch
// One timing channel: pclk divider, oversample counter and edge decode (RX vote/sample or TX wrap).
module uart_baud_gen_ch
    import uart_baud_gen_pkg::*;
#(
    parameter ch_mode_e MODE   = CH_RX,
    parameter int       DIV_W  = DIV_W_DEF,
    parameter int       OVS    = OVS_DEF
`ifdef UART_FRAC_DIV_EN
   ,parameter int       FRAC_W = FRAC_W_DEF
`endif
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic              en_i,
    input  logic              restart_i,
    input  logic [DIV_W-1:0]  div_i,
`ifdef UART_FRAC_DIV_EN
    input  logic [FRAC_W-1:0] dlf_i,
`endif
    output edges_t            edges_o
);

    localparam int OVS_W = $clog2(OVS);
    localparam int MID   = OVS / 2;

    logic [DIV_W-1:0] div_cnt_q;
    logic [DIV_W-1:0] div_cnt_d;
    logic [DIV_W-1:0] reload;
    logic [OVS_W-1:0] ovs_cnt_q;
    logic [OVS_W-1:0] ovs_cnt_d;
    logic [OVS_W-1:0] ovs_next;
    logic             tick;

    // A restart suppresses the tick it coincides with.
    assign tick     = en_i && !restart_i && (div_i != '0) && (div_cnt_q == div_i);
    assign ovs_next = (ovs_cnt_q == OVS_W'(OVS - 1)) ? '0 : ovs_cnt_q + OVS_W'(1);

`ifdef UART_FRAC_DIV_EN
    logic [FRAC_W-1:0] acc_q;
    logic [FRAC_W-1:0] acc_d;
    logic [FRAC_W:0]   acc_sum;

    assign acc_sum = {1'b0, acc_q} + {1'b0, dlf_i};
    // Carry restarts the count at 0, making the following period DIV+1 cycles.
    assign reload  = acc_sum[FRAC_W] ? '0 : DIV_W'(1);

    always_comb begin
        acc_d = acc_q;
        if (restart_i) begin
            acc_d = '0;
        end else if (tick) begin
            acc_d = acc_sum[FRAC_W-1:0];
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end
`else
    assign reload = DIV_W'(1);
`endif

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        div_cnt_d = div_cnt_q;
        ovs_cnt_d = ovs_cnt_q;
        if (restart_i) begin
            div_cnt_d = DIV_W'(1);
            ovs_cnt_d = '0;
        end else if (tick) begin
            div_cnt_d = reload;
            ovs_cnt_d = ovs_next;
        end else if (en_i && (div_i != '0)) begin
            div_cnt_d = div_cnt_q + DIV_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            div_cnt_q <= DIV_W'(1);
            ovs_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
            ovs_cnt_q <= ovs_cnt_d;
        end
    end

    generate
        if (MODE == CH_RX) begin : g_rx
            always_comb begin
                edges_o        = '0;
                edges_o.vote   = tick && ((ovs_next == OVS_W'(MID - 1)) ||
                                          (ovs_next == OVS_W'(MID))     ||
                                          (ovs_next == OVS_W'(MID + 1)));
                edges_o.sample = tick && (ovs_next == OVS_W'(MID + 2));
            end
        end else begin : g_tx
            always_comb begin
                edges_o      = '0;
                edges_o.xmit = tick && (ovs_next == '0);
            end
        end
    endgenerate

endmodule

// File: rtl/uart_baud_gen.sv
// Module: uart_baud_gen
// Two-channel UART baud timing generator; define UART_FRAC_DIV_EN to add the dlf fractional divisor.
module uart_baud_gen
    import uart_baud_gen_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF,
    parameter int OVS   = OVS_DEF
) (
    input  logic           pclk,
    input  logic           presetn,
    uart_baud_gen_if.slave bus
);

    logic [15:0]      dl_full;
    logic [DIV_W-1:0] div_live;
    logic [DIV_W-1:0] shadow_q;
    logic             div_chg;
    logic             rx_restart;
    logic             tx_restart;
    edges_t           rx_edges;
    edges_t           tx_edges;
    logic             voting_edge_q;
    logic             sample_edge_q;
    logic             transmit_edge_q;
    logic             unused_edges;

    assign dl_full  = {bus.dlh, bus.dll};
    assign div_live = dl_full[DIV_W-1:0];

`ifdef UART_FRAC_DIV_EN
    logic [FRAC_W_DEF-1:0] dlf_shadow_q;

    assign div_chg = (div_live != shadow_q) || (bus.dlf != dlf_shadow_q);

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            dlf_shadow_q <= '0;
        end else begin
            dlf_shadow_q <= bus.dlf;
        end
    end
`else
    assign div_chg = (div_live != shadow_q);
`endif

    // A divisor rewrite restarts both channels exactly like their clears.
    assign rx_restart = bus.rx_clr || div_chg;
    assign tx_restart = bus.tx_clr || div_chg;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            shadow_q <= '0;
        end else begin
            shadow_q <= div_live;
        end
    end

    uart_baud_gen_ch #(
        .MODE  (CH_RX),
        .DIV_W (DIV_W),
        .OVS   (OVS)
    ) u_rx_ch (
        .pclk      (pclk),
        .presetn   (presetn),
        .en_i      (bus.en),
        .restart_i (rx_restart),
        .div_i     (shadow_q),
`ifdef UART_FRAC_DIV_EN
        .dlf_i     (bus.dlf),
`endif
        .edges_o   (rx_edges)
    );

    uart_baud_gen_ch #(
        .MODE  (CH_TX),
        .DIV_W (DIV_W),
        .OVS   (OVS)
    ) u_tx_ch (
        .pclk      (pclk),
        .presetn   (presetn),
        .en_i      (bus.en),
        .restart_i (tx_restart),
        .div_i     (shadow_q),
`ifdef UART_FRAC_DIV_EN
        .dlf_i     (bus.dlf),
`endif
        .edges_o   (tx_edges)
    );

    assign unused_edges = ^{rx_edges.xmit, tx_edges.vote, tx_edges.sample};

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            voting_edge_q   <= 1'b0;
            sample_edge_q   <= 1'b0;
            transmit_edge_q <= 1'b0;
        end else begin
            voting_edge_q   <= rx_edges.vote;
            sample_edge_q   <= rx_edges.sample;
            transmit_edge_q <= tx_edges.xmit;
        end
    end

    assign bus.voting_edge   = voting_edge_q;
    assign bus.sample_edge   = sample_edge_q;
    assign bus.transmit_edge = transmit_edge_q;

endmodule
